// File: rtl/vec_div_seq.sv
// rtl/vec_div_seq.sv - vector fixed-point divider, NUM_DIV shared shift-subtract units over ARR_WIDTH/NUM_DIV passes
module vec_div_seq #(
  parameter int ARR_WIDTH = 8,
  parameter int FXP_N     = 16,
  parameter int FXP_R     = 8,
  parameter int NUM_DIV   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         mode,
  input  logic                         sat_mode,
  input  logic [ARR_WIDTH*FXP_N-1:0]   in_a,
  input  logic [ARR_WIDTH*FXP_N-1:0]   in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ARR_WIDTH*FXP_N-1:0]   out,
  output logic [ARR_WIDTH-1:0]         dbz_mask,
  output logic [ARR_WIDTH-1:0]         ovf_mask,
  output logic                         dbz,
  output logic                         ovf,
  output logic                         busy
);
  localparam int PASSES = ARR_WIDTH / NUM_DIV;
  localparam int ITER   = FXP_N + FXP_R;
  localparam int G_W    = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int C_W    = $clog2(ITER + 1);
  localparam logic [FXP_N-1:0] MAX_POS = {1'b0, {(FXP_N-1){1'b1}}};
  localparam logic [FXP_N-1:0] MIN_NEG = {1'b1, {(FXP_N-1){1'b0}}};
  localparam logic [ITER-1:0]  LIM_POS = ITER'((1 << (FXP_N-1)) - 1);
  localparam logic [ITER-1:0]  LIM_NEG = ITER'(1 << (FXP_N-1));

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_CALC, S_WB, S_DONE} state_t;
  state_t r_state;
  state_t w_state_next;

  logic [ARR_WIDTH-1:0][FXP_N-1:0] r_a;
  logic [ARR_WIDTH-1:0][FXP_N-1:0] r_b;
  logic                            r_sat;
  logic [G_W-1:0]                  r_g;
  logic [C_W-1:0]                  r_cnt;
  logic [NUM_DIV-1:0][FXP_N:0]     r_rem;
  logic [NUM_DIV-1:0][ITER-1:0]    r_quo;
  logic [NUM_DIV-1:0][FXP_N-1:0]   r_dvs;
  logic [NUM_DIV-1:0]              r_neg, r_a_neg, r_a_zero, r_b_zero;
  logic [ARR_WIDTH-1:0][FXP_N-1:0] r_buf, r_out;
  logic [ARR_WIDTH-1:0]            r_dbz_buf, r_ovf_buf, r_dbz_out, r_ovf_out;

  logic [NUM_DIV-1:0][FXP_N:0]     w_shift, w_rem_next;
  logic [NUM_DIV-1:0][ITER-1:0]    w_quo_next;
  logic [NUM_DIV-1:0][FXP_N-1:0]   w_res;
  logic [NUM_DIV-1:0]              w_res_dbz, w_res_ovf;
  logic [ARR_WIDTH-1:0][FXP_N-1:0] w_buf_next;
  logic [ARR_WIDTH-1:0]            w_dbz_next, w_ovf_next;
  logic                            w_last_pass, w_calc_last;

  function automatic logic [FXP_N-1:0] f_mag(input logic [FXP_N-1:0] v);
    return v[FXP_N-1] ? -v : v;
  endfunction

  assign w_last_pass = (r_g == G_W'(PASSES - 1));
  assign w_calc_last = (r_cnt == C_W'(ITER - 1));

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_next = S_SETUP;
      end
      S_SETUP: w_state_next = S_CALC;
      S_CALC:  if (w_calc_last) w_state_next = S_WB;
      S_WB:    w_state_next = w_last_pass ? S_DONE : S_SETUP;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Restoring step: remainder is one bit wider than the divisor so the trial subtract never wraps.
  always_comb begin
    for (int u = 0; u < NUM_DIV; u++) begin
      w_shift[u] = {r_rem[u][FXP_N-1:0], r_quo[u][ITER-1]};
      if (w_shift[u] >= {1'b0, r_dvs[u]}) begin
        w_rem_next[u] = w_shift[u] - {1'b0, r_dvs[u]};
        w_quo_next[u] = {r_quo[u][ITER-2:0], 1'b1};
      end else begin
        w_rem_next[u] = w_shift[u];
        w_quo_next[u] = {r_quo[u][ITER-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    for (int u = 0; u < NUM_DIV; u++) begin
      w_res_dbz[u] = r_b_zero[u];
      w_res_ovf[u] = 1'b0;
      w_res[u]     = '0;
      if (r_b_zero[u]) begin
        if (r_sat && !r_a_zero[u]) w_res[u] = r_a_neg[u] ? MIN_NEG : MAX_POS;
      end else if (r_neg[u]) begin
        w_res_ovf[u] = (r_quo[u] > LIM_NEG);
        w_res[u]     = w_res_ovf[u] ? MIN_NEG : -r_quo[u][FXP_N-1:0];
      end else begin
        w_res_ovf[u] = (r_quo[u] > LIM_POS);
        w_res[u]     = w_res_ovf[u] ? MAX_POS : r_quo[u][FXP_N-1:0];
      end
    end
  end

  always_comb begin
    w_buf_next = r_buf;
    w_dbz_next = r_dbz_buf;
    w_ovf_next = r_ovf_buf;
    for (int p = 0; p < PASSES; p++) begin
      if (r_g == G_W'(p)) begin
        for (int u = 0; u < NUM_DIV; u++) begin
          w_buf_next[p*NUM_DIV+u] = w_res[u];
          w_dbz_next[p*NUM_DIV+u] = w_res_dbz[u];
          w_ovf_next[p*NUM_DIV+u] = w_res_ovf[u];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_g       <= '0;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sat     <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_neg     <= '0;
      r_a_neg   <= '0;
      r_a_zero  <= '0;
      r_b_zero  <= '0;
      r_buf     <= '0;
      r_dbz_buf <= '0;
      r_ovf_buf <= '0;
      r_out     <= '0;
      r_dbz_out <= '0;
      r_ovf_out <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= in_a;
            r_b   <= mode ? {ARR_WIDTH{in_b[FXP_N-1:0]}} : in_b;
            r_sat <= sat_mode;
            r_g   <= '0;
          end
        end
        S_SETUP: begin
          r_cnt <= '0;
          for (int p = 0; p < PASSES; p++) begin
            if (r_g == G_W'(p)) begin
              for (int u = 0; u < NUM_DIV; u++) begin
                r_quo[u]    <= ITER'(f_mag(r_a[p*NUM_DIV+u])) << FXP_R;
                r_rem[u]    <= '0;
                r_dvs[u]    <= f_mag(r_b[p*NUM_DIV+u]);
                r_neg[u]    <= r_a[p*NUM_DIV+u][FXP_N-1] ^ r_b[p*NUM_DIV+u][FXP_N-1];
                r_a_neg[u]  <= r_a[p*NUM_DIV+u][FXP_N-1];
                r_a_zero[u] <= (r_a[p*NUM_DIV+u] == '0);
                r_b_zero[u] <= (r_b[p*NUM_DIV+u] == '0);
              end
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + C_W'(1);
        end
        S_WB: begin
          r_buf     <= w_buf_next;
          r_dbz_buf <= w_dbz_next;
          r_ovf_buf <= w_ovf_next;
          if (w_last_pass) begin
            r_out     <= w_buf_next;
            r_dbz_out <= w_dbz_next;
            r_ovf_out <= w_ovf_next;
            r_g       <= '0;
          end else begin
            r_g <= r_g + G_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out      = r_out;
  assign dbz_mask = r_dbz_out;
  assign ovf_mask = r_ovf_out;
  assign dbz      = |r_dbz_out;
  assign ovf      = |r_ovf_out;

endmodule

// File: tb/tb_vec_div_seq.sv
// tb/tb_vec_div_seq.sv - randomized bench for vec_div_seq against an arithmetic reference model
module tb_vec_div_seq;
  localparam int LAT = 104;

  logic         clk, rst, in_valid, in_ready, mode, sat_mode, out_valid, out_ready;
  logic         dbz, ovf, busy;
  logic [127:0] in_a, in_b, out;
  logic [7:0]   dbz_mask, ovf_mask;

  vec_div_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sat_mode(sat_mode), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .dbz_mask(dbz_mask), .ovf_mask(ovf_mask), .dbz(dbz), .ovf(ovf), .busy(busy)
  );

  typedef struct {
    logic [127:0] out;
    logic [7:0]   dbz;
    logic [7:0]   ovf;
    int           acc;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         hold;
  int           checks = 0, errors = 0;
  int           cyc = 0, hs_cyc = 0, last_acc = 0, rdy_mode = 0;
  logic         prev_valid = 1'b0;
  logic [127:0] dut_last_out;
  logic [7:0]   dut_last_dbz, dut_last_ovf;
  logic         dut_last_dbz_agg, dut_last_ovf_agg;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Returns {ovf, dbz, q}
  function automatic logic [17:0] model_lane(input logic signed [15:0] a, input logic signed [15:0] b, input logic s);
    longint q;
    if (b == 0) begin
      if (s && a > 0) return {2'b01, 16'h7FFF};
      if (s && a < 0) return {2'b01, 16'h8000};
      return {2'b01, 16'h0000};
    end
    q = (longint'(a) * 256) / longint'(b);
    if (q > 32767)  return {2'b10, 16'h7FFF};
    if (q < -32768) return {2'b10, 16'h8000};
    return {2'b00, q[15:0]};
  endfunction

  function automatic exp_t model_vec(input logic [127:0] a, input logic [127:0] b, input logic m, input logic s);
    exp_t e;
    logic [17:0] r;
    for (int i = 0; i < 8; i++) begin
      r = model_lane(a[i*16 +: 16], m ? b[15:0] : b[i*16 +: 16], s);
      e.out[i*16 +: 16] = r[15:0];
      e.dbz[i] = r[16];
      e.ovf[i] = r[17];
    end
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [127:0] rand_vec();
    logic [127:0] v;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 5))
        0:       v[i*16 +: 16] = 16'h0000;
        1:       v[i*16 +: 16] = 16'h8000;
        2:       v[i*16 +: 16] = 16'h7FFF;
        3:       v[i*16 +: 16] = 16'($urandom_range(0, 1023));
        4:       v[i*16 +: 16] = -16'($urandom_range(1, 1023));
        default: v[i*16 +: 16] = 16'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic send(input logic [127:0] a, input logic [127:0] b, input logic m, input logic s);
    exp_t e;
    int   t;
    e = model_vec(a, b, m, s);
    in_a = a; in_b = b; mode = m; sat_mode = s; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("send_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    e.acc = cyc;
    last_acc = cyc;
    exp_q.push_back(e);
    in_valid = 1'b0;
    in_a = {$urandom, $urandom, $urandom, $urandom};
    in_b = {$urandom, $urandom, $urandom, $urandom};
    mode = 1'($urandom);
    sat_mode = 1'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Edge counter and output-handshake scoreboard pop
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst && out_valid && out_ready && exp_q.size() > 0) begin
        hold = exp_q[0];
        dut_last_out = out;
        dut_last_dbz = dbz_mask;
        dut_last_ovf = ovf_mask;
        dut_last_dbz_agg = dbz;
        dut_last_ovf_agg = ovf;
        void'(exp_q.pop_front());
        hs_cyc = cyc;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (out_valid) begin
          if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 1'b0);
          else begin
            if (!prev_valid) chk("latency", cyc - exp_q[0].acc, LAT);
            chk("out", out, exp_q[0].out);
            chk("dbz_mask", dbz_mask, exp_q[0].dbz);
            chk("ovf_mask", ovf_mask, exp_q[0].ovf);
            chk("dbz", dbz, |exp_q[0].dbz);
            chk("ovf", ovf, |exp_q[0].ovf);
          end
        end else begin
          chk("out_hold", out, hold.out);
          chk("dbz_mask_hold", dbz_mask, hold.dbz);
          chk("ovf_mask_hold", ovf_mask, hold.ovf);
          chk("dbz_hold", dbz, |hold.dbz);
          chk("ovf_hold", ovf, |hold.ovf);
        end
        chk("in_ready", in_ready, exp_q.size() == 0);
        chk("busy", busy, exp_q.size() != 0);
        prev_valid = out_valid;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [127:0] a, b;
    int           t;
    hold.out = '0; hold.dbz = '0; hold.ovf = '0; hold.acc = 0;
    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; sat_mode = 1'b0; in_a = '0; in_b = '0;

    chk("pin_l0", model_lane(16'h0180, 16'h0080, 1'b0), {2'b00, 16'h0300});
    chk("pin_l1", model_lane(16'hFF00, 16'h0400, 1'b0), {2'b00, 16'hFFC0});
    chk("pin_l2", model_lane(16'h0100, 16'h0300, 1'b0), {2'b00, 16'h0055});
    chk("pin_l3", model_lane(16'hFF00, 16'h0300, 1'b0), {2'b00, 16'hFFAB});
    chk("pin_ovf", model_lane(16'h6400, 16'h0040, 1'b0), {2'b10, 16'h7FFF});
    chk("pin_min", model_lane(16'h8000, 16'h0100, 1'b0), {2'b00, 16'h8000});
    chk("pin_minneg", model_lane(16'h8000, 16'hFF00, 1'b0), {2'b10, 16'h7FFF});
    chk("pin_dbz_sat", model_lane(16'hFE00, 16'h0000, 1'b1), {2'b01, 16'h8000});

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out", out, 128'h0);
    chk("rst_masks", {dbz_mask, ovf_mask, dbz, ovf}, 18'h0);
    rst = 1'b0;
    @(negedge clk);

    a = {16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 16'h0180};
    b = {16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0300, 16'h0300, 16'h0400, 16'h0080};
    send(a, b, 1'b0, 1'b0);
    wait_idle();
    chk("t1_lanes", dut_last_out[63:0], {16'hFFAB, 16'h0055, 16'hFFC0, 16'h0300});
    chk("t1_masks", {dut_last_dbz, dut_last_ovf}, 16'h0);

    a = {{5{16'h0000}}, 16'h8000, 16'h8000, 16'h6400};
    b = {{5{16'h0100}}, 16'hFF00, 16'h0100, 16'h0040};
    send(a, b, 1'b0, 1'b0);
    wait_idle();
    chk("t2_lanes", dut_last_out[47:0], {16'h7FFF, 16'h8000, 16'h7FFF});
    chk("t2_ovf_mask", dut_last_ovf, 8'h05);
    chk("t2_ovf", dut_last_ovf_agg, 1'b1);

    a = {{5{16'h0100}}, 16'h0000, 16'hFE00, 16'h0100};
    b = {{5{16'h0100}}, 16'h0000, 16'h0000, 16'h0000};
    send(a, b, 1'b0, 1'b0);
    wait_idle();
    chk("t3_zero_lanes", dut_last_out[47:0], 48'h0);
    chk("t3_dbz_mask", dut_last_dbz, 8'h07);
    send(a, b, 1'b0, 1'b1);
    wait_idle();
    chk("t3_sat_lanes", dut_last_out[47:0], {16'h0000, 16'h8000, 16'h7FFF});
    chk("t3_sat_masks", {dut_last_dbz, dut_last_ovf, dut_last_dbz_agg}, {8'h07, 8'h00, 1'b1});

    for (int i = 0; i < 8; i++) a[i*16 +: 16] = 16'(i * 256);
    b = 128'h0200;
    send(a, b, 1'b1, 1'b0);
    wait_idle();
    for (int i = 0; i < 8; i++) chk("t4_bcast_lane", dut_last_out[i*16 +: 16], 16'(i * 128));
    chk("t4_dbz", dut_last_dbz, 8'h00);

    rdy_mode = 2;
    @(negedge clk);
    send(rand_vec(), rand_vec(), 1'b0, 1'b1);
    t = 0;
    while (!out_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_rise", out_valid, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp_valid_held", out_valid, 1'b1);
      chk("bp_in_ready_low", in_ready, 1'b0);
    end
    rdy_mode = 0;
    send(rand_vec(), rand_vec(), 1'b0, 1'b0);
    chk("bp_next_accept", last_acc - hs_cyc, 1);
    wait_idle();

    send(rand_vec(), rand_vec(), 1'b0, 1'b1);
    repeat (62) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    hold.out = '0; hold.dbz = '0; hold.ovf = '0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_out", out, 128'h0);
    chk("mid_rst_flags", {dbz_mask, ovf_mask, dbz, ovf}, 18'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    send(rand_vec(), rand_vec(), 1'b0, 1'b1);
    wait_idle();

    for (int n = 0; n < 30; n++) begin
      rdy_mode = int'($urandom_range(0, 1));
      send(rand_vec(), rand_vec(), 1'($urandom), 1'($urandom));
    end
    rdy_mode = 0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
